// File: rtl/frame_window_reader.sv
// frame_window_reader
// Read-side client of the SRAM frame buffer. On a start handshake it latches a
// rectangular window, issues word reads row by row on the arbiter R1 port,
// buffers the returned words in a small FIFO and unpacks each word into four
// 8-bit pixels (pixel 0 in bits [7:0]) with start-of-frame, end-of-line and
// end-of-frame markers.
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   start / start_ack      window request handshake (ack is a one-cycle pulse)
//   win_x, win_y           window top-left corner (win_x[1:0] ignored)
//   win_w, win_h           window size in pixels / rows (win_w[1:0] ignored)
//   done / done_ack        completion flag and its clear
//   busy                   high whenever the reader is not idle
//   addr, addr_valid,      word read request towards the arbiter
//   addr_ready
//   data, data_valid,      read data returned in request order
//   data_ready
//   pix, pix_valid,        one-pixel-per-beat output stream with markers
//   pix_ready, pix_sof,
//   pix_eol, pix_eof
module frame_window_reader #(
    parameter int          IMG_WIDTH  = 800,
    parameter int          IMG_HEIGHT = 600,
    parameter logic [17:0] BASE_ADDR  = 18'd0,
    parameter int          DEPTH      = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        start_ack,
    input  logic [9:0]  win_x,
    input  logic [9:0]  win_y,
    input  logic [10:0] win_w,
    input  logic [10:0] win_h,
    output logic        done,
    input  logic        done_ack,
    output logic        busy,
    output logic [17:0] addr,
    output logic        addr_valid,
    input  logic        addr_ready,
    input  logic [31:0] data,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [7:0]  pix,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_eof
);

    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [17:0] WPR     = 18'(IMG_WIDTH / 4);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Reject parameter sets the address arithmetic and FIFO cannot support.
    if ((IMG_WIDTH % 4) != 0 || IMG_HEIGHT < 1 || DEPTH < 2 || DEPTH > 16 ||
        (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("frame_window_reader: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            run_q;
    logic [7:0]      lat_wx;
    logic [9:0]      lat_y;
    logic [8:0]      lat_ww;
    logic [10:0]     lat_h;

    logic [17:0]     row_base;
    logic [17:0]     cur_addr;
    logic [8:0]      col_cnt;
    logic [10:0]     row_cnt;
    logic [CW-1:0]   credits;

    logic [31:0]     fifo_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_cnt;

    logic [1:0]      cur_beat;
    logic [10:0]     out_col;
    logic [10:0]     out_row;

    logic            win_empty;
    logic            addr_fire;
    logic            issue_last;
    logic            push;
    logic            pop;
    logic            pix_take;
    logic            slot_free;
    logic            unpack_on;
    logic            load;
    logic [31:0]     src_word;
    logic [1:0]      src_beat;
    logic            src_avail;
    logic            sof_n;
    logic            eol_n;
    logic            eof_n;
    logic [17:0]     first_base;
    logic            unused_bits;

    // The low bits of the x position and width select pixels inside a word
    // and have no meaning for a word-granular reader.
    assign unused_bits = ^{win_x[1:0], win_w[1:0]};

    assign start_ack  = run_q && (state == IDLE) && start;
    assign win_empty  = (win_w[10:2] == 9'd0) || (win_h == 11'd0);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign data_ready = run_q;
    assign addr       = cur_addr;
    assign addr_valid = (state == ISSUE) && (credits < DEPTH_C);
    assign addr_fire  = addr_valid && addr_ready;
    assign issue_last = addr_fire && (col_cnt == lat_ww - 9'd1) && (row_cnt == lat_h - 11'd1);

    // Word address of the window's first pixel; WPR is a constant so the
    // product reduces to shifts and adds.
    assign first_base = BASE_ADDR + (18'(lat_y) * WPR) + 18'(lat_wx);

    // A return is only stored if a read for it is still outstanding; this
    // drops returns for reads issued before an abort and bounds the FIFO.
    assign push = data_valid && (credits > fifo_cnt);

    assign pix_take  = pix_valid && pix_ready;
    assign slot_free = !pix_valid || pix_take;
    assign pop       = pix_take && (cur_beat == 2'd3);
    assign unpack_on = (state == ISSUE) || (state == DRAIN);
    assign load      = unpack_on && slot_free && src_avail;

    // data_ready is held low during reset and high once reset is released.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; empty windows skip straight to DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ack) state_next = win_empty ? DONE : SETUP;
            SETUP:   state_next = ISSUE;
            ISSUE:   if (issue_last) state_next = DRAIN;
            DRAIN:   if (pix_take && pix_eof) state_next = DONE;
            DONE:    if (done_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Window latch and read address generation. Each row restarts from the
    // previous row base plus one frame row of words.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_wx   <= '0;
            lat_y    <= '0;
            lat_ww   <= '0;
            lat_h    <= '0;
            row_base <= '0;
            cur_addr <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
        end else begin
            if (start_ack) begin
                lat_wx <= win_x[9:2];
                lat_y  <= win_y;
                lat_ww <= win_w[10:2];
                lat_h  <= win_h;
            end
            if (state == SETUP) begin
                row_base <= first_base;
                cur_addr <= first_base;
                col_cnt  <= '0;
                row_cnt  <= '0;
            end else if (addr_fire) begin
                if (col_cnt == lat_ww - 9'd1) begin
                    col_cnt  <= '0;
                    row_cnt  <= row_cnt + 11'd1;
                    row_base <= row_base + WPR;
                    cur_addr <= row_base + WPR;
                end else begin
                    col_cnt  <= col_cnt + 9'd1;
                    cur_addr <= cur_addr + 18'd1;
                end
            end
        end
    end

    // Credits count words issued but not yet fully unpacked, so the FIFO can
    // always absorb every outstanding return.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            credits <= '0;
        end else begin
            case ({addr_fire, pop})
                2'b10:   credits <= credits + CW'(1);
                2'b01:   credits <= credits - CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Pick the next pixel to load. The head word stays in the FIFO until its
    // last pixel is accepted, so when pixel 3 is on the output the following
    // word is read one slot behind the head to keep one pixel per clock.
    always_comb begin
        src_word  = fifo_mem[rd_ptr];
        src_beat  = 2'd0;
        src_avail = 1'b0;
        if (pix_valid && (cur_beat != 2'd3)) begin
            src_beat  = cur_beat + 2'd1;
            src_avail = 1'b1;
        end else if (pix_valid) begin
            src_word  = fifo_mem[rd_ptr + 1'b1];
            src_avail = (fifo_cnt >= CW'(2));
        end else begin
            src_avail = (fifo_cnt != '0);
        end
    end

    // Markers for the pixel about to be loaded, from its window position.
    always_comb begin
        sof_n = (out_col == 11'd0) && (out_row == 11'd0);
        eol_n = (out_col == {lat_ww - 9'd1, 2'b11});
        eof_n = eol_n && (out_row == lat_h - 11'd1);
    end

    // Registered output stage; it only changes when empty or accepted, so
    // everything holds steady under backpressure.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pix       <= '0;
            pix_valid <= 1'b0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            pix_eof   <= 1'b0;
            cur_beat  <= '0;
            out_col   <= '0;
            out_row   <= '0;
        end else begin
            if (start_ack) begin
                out_col <= '0;
                out_row <= '0;
            end
            if (load) begin
                pix       <= src_word[{src_beat, 3'b000} +: 8];
                pix_valid <= 1'b1;
                pix_sof   <= sof_n;
                pix_eol   <= eol_n;
                pix_eof   <= eof_n;
                cur_beat  <= src_beat;
                if (eol_n) begin
                    out_col <= '0;
                    out_row <= out_row + 11'd1;
                end else begin
                    out_col <= out_col + 11'd1;
                end
            end else if (pix_take) begin
                pix_valid <= 1'b0;
                pix_sof   <= 1'b0;
                pix_eol   <= 1'b0;
                pix_eof   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/frame_window_reader.md
Name: frame_window_reader

Overview:
- Read-side client for the SRAM frame buffer filled by the image buffer writer. Attaches to the arbiter's spare R1 port (addr and data ready/valid pair).
- On a start handshake it fetches a rectangular window of 8-bit grayscale pixels in row-major order. It buffers the returned words and unpacks them into a one-pixel-per-beat stream with frame/line markers for the SIFT pipeline.
- Runs entirely in the SRAM-client clock domain; the arbiter handles the crossing to the SRAM clock.

Parameters:
- IMG_WIDTH, 800, frame width in pixels; must be a multiple of 4.
- IMG_HEIGHT, 600, frame height in pixels.
- BASE_ADDR, 18'd0, word address of pixel (0,0).
- DEPTH, 4, maximum words in flight plus buffered; power of 2, from 2 to 16.

Ports:
- clock  in  1  sole clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- start  in  1  request; held high by the requester until start_ack.
- start_ack  out  1  one-cycle pulse when the window is latched.
- win_x  in  10  window left edge in pixels; bits[1:0] ignored.
- win_y  in  10  window top row.
- win_w  in  11  window width in pixels; bits[1:0] ignored.
- win_h  in  11  window height in rows.
- done  out  1  high from the last pixel accepted until done_ack.
- done_ack  in  1  clears done.
- busy  out  1  high in any state other than IDLE.
- addr  out  18  word read address sent to the arbiter.
- addr_valid  out  1  addr is valid.
- addr_ready  in  1  arbiter accepts addr.
- data  in  32  read word; pixel k (k = 0..3) is in bits [8k+7:8k].
- data_valid  in  1  data is valid.
- data_ready  out  1  always 1 outside reset.
- pix  out  8  pixel value.
- pix_valid  out  1  pix is valid.
- pix_ready  in  1  downstream accepts pix.
- pix_sof  out  1  first pixel of the window.
- pix_eol  out  1  last pixel of each row.
- pix_eof  out  1  last pixel of the window.

Behaviour:
- Reset (reset=0): state IDLE; all outputs 0 except data_ready=0; FIFO, counters and credits cleared; latched window discarded.
- Word geometry: WPR = IMG_WIDTH/4 (constant).
  - ww = win_w[10:2], start word column wx = win_x[9:2].
  - Row base = BASE_ADDR + win_y*WPR + wx, computed once at latch time (multi-cycle or constant-shift implementation allowed, at most 4 cycles).
  - Each subsequent row adds WPR to the row base; no multiplier in the issue loop.
  - All addresses are 18-bit and wrap mod 2^18. No clipping against IMG_WIDTH/IMG_HEIGHT.
- States: IDLE -> SETUP -> ISSUE -> DRAIN -> DONE -> IDLE.
  - IDLE:
    - If start=1, latch win_*, pulse start_ack, go to SETUP.
    - If ww=0 or win_h=0, go directly to DONE with no SRAM traffic and no pixels.
  - SETUP: compute the first row base, then go to ISSUE.
  - ISSUE:
    - Present addr with addr_valid=1 only when credits < DEPTH, where credits = words issued minus words popped from the FIFO.
    - Hold addr and addr_valid stable until addr_ready.
    - After ww*win_h words are issued, go to DRAIN.
  - DRAIN: wait until the last pixel handshake (pix_valid & pix_ready with pix_eof) completes, then go to DONE.
  - DONE: done=1; when done_ack=1 return to IDLE, with done=0 the next cycle.
- start is ignored outside IDLE; start_ack never pulses while busy.
- Return path:
  - data_valid always pushes into a DEPTH-word FIFO. The credit rule guarantees it never overflows.
  - A push arriving when credits=0 (stale return after reset) is dropped.
  - Returns are in order; no tagging.
- Unpacker:
  - Pops a FIFO word and emits 4 beats, pixel 0 first.
  - pix, pix_valid and flags are registered and hold stable while pix_valid & !pix_ready.
  - Pop occurs on acceptance of pixel 3. A same-cycle FIFO push and pop is allowed.
- Flags:
  - pix_sof on pixel (0,0) of the window.
  - pix_eol on the last pixel of each row.
  - pix_eof together with pix_eol on the last row.
- Latency: first pix_valid no earlier than 2 cycles after the first data_valid. Sustained rate is 1 pixel/clock when pix_ready=1 and the arbiter keeps up.
- Asynchronous reset mid-transfer aborts immediately: outstanding reads are forgotten and no done is produced.

Test Plan:
- Basic window: win_x=4, win_y=2, win_w=8, win_h=2, IMG_WIDTH=800, BASE_ADDR=0; model memory where word a = {a[7:0]+3, a[7:0]+2, a[7:0]+1, a[7:0]} -> addr sequence 401, 402, 601, 602; 16 pixels starting 0x91, 0x92, …; sof on pixel 0, eol on pixels 7 and 15, eof on pixel 15; done then done_ack -> IDLE.
- Credit limit: DEPTH=4, arbiter accepts every addr but withholds data for 20 cycles -> exactly 4 addr handshakes, then addr_valid=0 until data returns; FIFO never exceeds 4.
- Backpressure: pix_ready toggles randomly at 30% -> pix, pix_valid and flags stable while stalled; no pixel lost or duplicated over a 32x8 window.
- Zero size: win_w=3 (ww=0) or win_h=0 -> start_ack, then done within 3 cycles; no addr_valid, no pix_valid.
- Wrap: BASE_ADDR=18'h3FFFF, window at (0,0), width 8, height 1 -> addresses 3FFFF, 00000.
- Reset mid-run: reset=0 during ISSUE with 3 reads outstanding, release, then 3 stale data_valid beats -> all dropped; a new start behaves exactly as the basic window case.
